// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared encodings for the sequenced binary-to-one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_LATCH = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_PULSE = 2'b10,
        ST_SCAN  = 2'b11
    } state_e;

    // Only LATCH and PULSE take a select from the input handshake.
    function automatic logic mode_accepts(logic [1:0] m);
        return (m == MODE_LATCH) || (m == MODE_PULSE);
    endfunction

endpackage

// File: rtl/decoder_nto2n_seq_if.sv
// Control/select handshake and decoded outputs of decoder_nto2n_seq.
interface decoder_nto2n_seq_if #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 2**SEL_W
);
    logic               en;
    logic [1:0]         mode;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic [NUM_OUT-1:0] y;
    logic               busy;
    logic               err;

    modport master (
        output en, mode, in_valid, in_sel,
        input  in_ready, y, busy, err
    );

    modport slave (
        input  en, mode, in_valid, in_sel,
        output in_ready, y, busy, err
    );
endinterface

// File: rtl/decoder_nto2n_seq_onehot_dec.sv
// Combinational binary-to-one-hot decode with out-of-range flag.
module onehot_dec #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 2**SEL_W
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot,
    output logic               oor
);
    // One extra bit so NUM_OUT == 2**SEL_W is representable in the compare.
    logic [SEL_W:0] sel_x;

    assign sel_x = {1'b0, sel};
    assign oor   = (sel_x >= (SEL_W+1)'(NUM_OUT));

    // Decode; an out-of-range select yields all zeros.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = (sel_x == (SEL_W+1)'(i));
        end
    end
endmodule

// File: rtl/decoder_nto2n_seq.sv
// Sequenced N-to-2^N decoder: latch, timed pulse and rotating scan modes.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | y cleared, waiting for a select or a scan request
// ST_HOLD  | latched select shown on y until next accept / en low
// ST_PULSE | select shown on y for PULSE_LEN cycles, mode ignored
// ST_SCAN  | single set bit rotating left once per cycle
module decoder_nto2n_seq #(
    parameter int SEL_W     = 3,
    parameter int NUM_OUT   = 2**SEL_W,
    parameter int PULSE_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_nto2n_seq_if.slave   bus
);
    import decoder_pkg::*;

    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    state_e             state_q, state_d;
    logic [NUM_OUT-1:0] y_q, y_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] dec_y;
    logic               dec_oor;
    logic               accept;

    onehot_dec #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec (
        .sel    (bus.in_sel),
        .onehot (dec_y),
        .oor    (dec_oor)
    );

    // rst gates ready so nothing is taken while the block is being cleared.
    assign bus.in_ready = !rst && bus.en
                          && (state_q == ST_IDLE || state_q == ST_HOLD)
                          && mode_accepts(bus.mode);
    assign accept   = bus.in_valid && bus.in_ready;
    assign bus.y    = y_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection; en low wins over mode and input.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (bus.mode == MODE_SCAN)
                        state_d = ST_SCAN;
                    else if (bus.mode == MODE_RSVD)
                        state_d = ST_IDLE;
                    else if (accept) begin
                        if (dec_oor)
                            state_d = ST_IDLE;
                        else if (bus.mode == MODE_LATCH)
                            state_d = ST_HOLD;
                        else
                            state_d = ST_PULSE;
                    end
                end
                ST_PULSE: if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
                ST_SCAN:  if (bus.mode != MODE_SCAN) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next output values, derived from the chosen next state.
    always_comb begin
        y_d    = y_q;
        cnt_d  = cnt_q;
        err_d  = accept && dec_oor;
        busy_d = (state_d == ST_PULSE) || (state_d == ST_SCAN);
        case (state_d)
            ST_IDLE: begin
                y_d   = '0;
                cnt_d = '0;
            end
            ST_HOLD: if (accept) y_d = dec_y;
            ST_PULSE: begin
                if (state_q != ST_PULSE) begin
                    y_d   = dec_y;
                    cnt_d = CNT_W'(PULSE_LEN);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (state_q != ST_SCAN)
                    y_d = {{(NUM_OUT-1){1'b0}}, 1'b1};
                else
                    y_d = {y_q[NUM_OUT-2:0], y_q[NUM_OUT-1]};
            end
            default: y_d = '0;
        endcase
    end
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench: each driven cycle queues the outputs expected after its edge.
module tb_decoder_nto2n_seq;

    typedef struct {
        bit         d6;
        logic [7:0] y;
        logic       err;
        logic       busy;
        logic       rdy;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst8, rst6;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t em;

    decoder_nto2n_seq_if #(.SEL_W(3), .NUM_OUT(8)) if8 ();
    decoder_nto2n_seq_if #(.SEL_W(3), .NUM_OUT(6)) if6 ();

    decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(8), .PULSE_LEN(4)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8)
    );

    decoder_nto2n_seq #(.SEL_W(3), .NUM_OUT(6), .PULSE_LEN(4)) dut6 (
        .clk (clk),
        .rst (rst6),
        .bus (if6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the selected DUT and queue what must follow its edge.
    task automatic cyc(input bit d6, input logic r, input logic e, input logic [1:0] m,
                       input logic v, input logic [2:0] s,
                       input logic [7:0] y, input logic er, input logic b, input logic rd,
                       input string tag);
        exp_t x;
        if (d6) begin
            rst6 = r; if6.en = e; if6.mode = m; if6.in_valid = v; if6.in_sel = s;
        end else begin
            rst8 = r; if8.en = e; if8.mode = m; if8.in_valid = v; if8.in_sel = s;
        end
        x.d6 = d6; x.y = y; x.err = er; x.busy = b; x.rdy = rd; x.tag = tag;
        sb.push_back(x);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            em = sb.pop_front();
            if (em.d6) begin
                chk({em.tag, ".y"},    32'(if6.y),        32'(em.y));
                chk({em.tag, ".err"},  32'(if6.err),      32'(em.err));
                chk({em.tag, ".busy"}, 32'(if6.busy),     32'(em.busy));
                chk({em.tag, ".rdy"},  32'(if6.in_ready), 32'(em.rdy));
            end else begin
                chk({em.tag, ".y"},    32'(if8.y),        32'(em.y));
                chk({em.tag, ".err"},  32'(if8.err),      32'(em.err));
                chk({em.tag, ".busy"}, 32'(if8.busy),     32'(em.busy));
                chk({em.tag, ".rdy"},  32'(if8.in_ready), 32'(em.rdy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        rst8 = 1'b1; if8.en = 1'b0; if8.mode = 2'b00; if8.in_valid = 1'b0; if8.in_sel = 3'd0;
        rst6 = 1'b1; if6.en = 1'b0; if6.mode = 2'b00; if6.in_valid = 1'b0; if6.in_sel = 3'd0;
        @(negedge clk);

        // reset, including ready held low while enabled
        cyc(0, 1, 0, 2'b00, 0, 0, 8'h00, 0, 0, 0, "rst0");
        cyc(0, 1, 1, 2'b00, 1, 2, 8'h00, 0, 0, 0, "rst_en");

        // LATCH
        cyc(0, 0, 1, 2'b00, 1, 5, 8'h20, 0, 0, 1, "latch5");
        cyc(0, 0, 1, 2'b00, 0, 0, 8'h20, 0, 0, 1, "hold5a");
        cyc(0, 0, 1, 2'b00, 0, 0, 8'h20, 0, 0, 1, "hold5b");
        cyc(0, 0, 1, 2'b00, 1, 0, 8'h01, 0, 0, 1, "latch0");
        cyc(0, 0, 1, 2'b00, 1, 1, 8'h02, 0, 0, 1, "b2b1");
        cyc(0, 0, 1, 2'b00, 1, 2, 8'h04, 0, 0, 1, "b2b2");
        cyc(0, 0, 1, 2'b00, 1, 3, 8'h08, 0, 0, 1, "b2b3");
        cyc(0, 0, 1, 2'b00, 0, 0, 8'h08, 0, 0, 1, "hold3");
        cyc(0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0, 0, "en_off_hold");

        // PULSE, in_valid held high throughout
        cyc(0, 0, 1, 2'b01, 1, 3, 8'h08, 0, 1, 0, "pulse_c1");
        cyc(0, 0, 1, 2'b01, 1, 6, 8'h08, 0, 1, 0, "pulse_c2");
        cyc(0, 0, 1, 2'b01, 1, 6, 8'h08, 0, 1, 0, "pulse_c3");
        cyc(0, 0, 1, 2'b01, 1, 6, 8'h08, 0, 1, 0, "pulse_c4");
        cyc(0, 0, 1, 2'b01, 1, 6, 8'h00, 0, 0, 1, "pulse_end");
        cyc(0, 0, 1, 2'b01, 0, 0, 8'h00, 0, 0, 1, "pulse_idle");

        // PULSE ignores a mode change until done
        cyc(0, 0, 1, 2'b01, 1, 1, 8'h02, 0, 1, 0, "pm_c1");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h02, 0, 1, 0, "pm_c2");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h02, 0, 1, 0, "pm_c3");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h02, 0, 1, 0, "pm_c4");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h00, 0, 0, 0, "pm_idle");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h01, 0, 1, 0, "pm_scan");
        cyc(0, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, "pm_exit");

        // SCAN for 10 cycles, then leave
        for (int i = 0; i < 10; i++) begin
            v = 8'h01 << (i % 8);
            cyc(0, 0, 1, 2'b10, 1, 3, v, 0, 1, 0, $sformatf("scan%0d", i));
        end
        cyc(0, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, "scan_exit");

        // reserved mode
        cyc(0, 0, 1, 2'b11, 1, 2, 8'h00, 0, 0, 0, "rsvd_a");
        cyc(0, 0, 1, 2'b11, 1, 2, 8'h00, 0, 0, 0, "rsvd_b");
        cyc(0, 0, 1, 2'b00, 1, 4, 8'h10, 0, 0, 1, "latch4");
        cyc(0, 0, 1, 2'b11, 0, 0, 8'h00, 0, 0, 0, "rsvd_hold");

        // reset in the 2nd PULSE cycle, then resume
        cyc(0, 0, 1, 2'b01, 1, 6, 8'h40, 0, 1, 0, "rp_c1");
        cyc(0, 0, 1, 2'b01, 0, 0, 8'h40, 0, 1, 0, "rp_c2");
        cyc(0, 1, 1, 2'b01, 0, 0, 8'h00, 0, 0, 0, "rp_rst");
        cyc(0, 0, 1, 2'b01, 0, 0, 8'h00, 0, 0, 1, "rp_idle");
        cyc(0, 0, 1, 2'b00, 1, 7, 8'h80, 0, 0, 1, "rp_resume");

        // reset mid-SCAN
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h01, 0, 1, 0, "rs_c1");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h02, 0, 1, 0, "rs_c2");
        cyc(0, 1, 1, 2'b10, 0, 0, 8'h00, 0, 0, 0, "rs_rst");
        cyc(0, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, "rs_idle");

        // en drop mid-SCAN
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h01, 0, 1, 0, "es_c1");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h02, 0, 1, 0, "es_c2");
        cyc(0, 0, 1, 2'b10, 0, 0, 8'h04, 0, 1, 0, "es_c3");
        cyc(0, 0, 0, 2'b10, 0, 0, 8'h00, 0, 0, 0, "es_off");
        cyc(0, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, "es_on");

        // NUM_OUT=6: out-of-range selects and scan wrap at bit 5
        cyc(1, 1, 0, 2'b00, 0, 0, 8'h00, 0, 0, 0, "n6_rst");
        cyc(1, 0, 1, 2'b00, 1, 6, 8'h00, 1, 0, 1, "n6_oor6");
        cyc(1, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, "n6_errclr");
        cyc(1, 0, 1, 2'b00, 1, 5, 8'h20, 0, 0, 1, "n6_sel5");
        cyc(1, 0, 1, 2'b00, 1, 7, 8'h00, 1, 0, 1, "n6_oor7");
        cyc(1, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, "n6_errclr2");
        for (int i = 0; i < 7; i++) begin
            v = 8'h01 << (i % 6);
            cyc(1, 0, 1, 2'b10, 0, 0, v, 0, 1, 0, $sformatf("n6_scan%0d", i));
        end
        cyc(1, 0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, "n6_scan_exit");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decoder_nto2n_seq.md
DECODER_NTO2N_SEQ -- requirements
Module: decoder_nto2n_seq

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width in bits.
REQ-002 SHALL have parameter NUM_OUT, default 2**SEL_W: number of one-hot outputs, legal range 2..2**SEL_W.
REQ-003 SHALL have parameter PULSE_LEN, default 4: pulse-mode output duration in cycles, legal range >= 1.
REQ-004 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1: block enable.
REQ-007 SHALL have port mode  input  2: 00 LATCH, 01 PULSE, 10 SCAN, 11 reserved.
REQ-008 SHALL have port in_valid  input  1: in_sel is valid.
REQ-009 SHALL have port in_ready  output  1: block accepts in_sel this cycle.
REQ-010 SHALL have port in_sel  input  SEL_W: binary select.
REQ-011 SHALL have port y  output  NUM_OUT: registered one-hot (or all-zero) output.
REQ-012 SHALL have port busy  output  1: high in PULSE or SCAN state.
REQ-013 SHALL have port err  output  1: one-cycle flag for an out-of-range select.

Function
REQ-014 SHALL implement the states IDLE, HOLD, PULSE and SCAN.
REQ-015 SHALL accept an input only on a cycle where in_valid && in_ready is true at the clock edge.
REQ-016 SHALL present y one cycle after acceptance (latency 1).
REQ-017 SHALL drive in_ready = en && (state is IDLE or HOLD) && (mode is LATCH or PULSE), as combinational logic from registered state.
REQ-018 SHALL, in LATCH mode on acceptance, load y with 1<<in_sel, enter HOLD, and keep y until the next acceptance or until en drops.
REQ-019 SHALL, in PULSE mode on acceptance, load y with 1<<in_sel, enter PULSE, and hold y for exactly PULSE_LEN cycles; it SHALL then clear y and return to IDLE.
REQ-020 SHALL use a PULSE-state counter of width $clog2(PULSE_LEN+1), loaded on acceptance and decremented each cycle; PULSE exits when the counter reaches 1.
REQ-021 SHALL, when mode==SCAN and en==1 in IDLE or HOLD, enter SCAN with y=1 on the next cycle.
REQ-022 SHALL, in SCAN, rotate y left by one position per cycle and wrap from bit NUM_OUT-1 to bit 0; in_sel and in_valid are ignored.
REQ-023 SHALL, when mode leaves SCAN, go from SCAN to IDLE with y=0 on the next cycle.
REQ-024 SHALL, in PULSE, ignore mode changes until the pulse completes; the new mode applies from IDLE onward.
REQ-025 SHALL, on acceptance with in_sel >= NUM_OUT, load y=0, assert err for exactly one cycle, and go to IDLE.
REQ-026 SHALL, with mode==11, hold in_ready low and keep y=0 from IDLE/HOLD.
REQ-027 SHALL, when en==0 in any state, go to IDLE with y=0 on the next cycle; en takes priority over mode and input.
REQ-028 SHALL, on back-to-back LATCH acceptances, update y every cycle with no bubble.
REQ-029 SHALL never have more than one bit of y set.

Reset
REQ-030 SHALL, while rst==1 at the clock edge, force state=IDLE, y=0, err=0, busy=0 and the pulse counter to 0.
REQ-031 SHALL hold in_ready low during rst, including a reset asserted mid-PULSE or mid-SCAN.
REQ-032 SHALL give rst priority over en, mode and every input.
REQ-033 SHALL resume normal operation on the first edge after rst falls.

Structure
REQ-034 SHALL place the mode encodings and the state enumeration in shared package decoder_pkg.
REQ-035 SHALL use one combinational sub-module, onehot_dec (parameters SEL_W and NUM_OUT; select in, one-hot out, plus an out-of-range flag), for the binary-to-one-hot decode.
REQ-036 SHALL have all outputs except in_ready come directly from flops.

Verification (SEL_W=3, NUM_OUT=8, PULSE_LEN=4 unless stated)
REQ-037 SHALL test LATCH: accept in_sel=5 -> y=8'h20 next cycle and held; then accept 0 -> y=8'h01; back-to-back 1,2,3 -> 8'h02, 8'h04, 8'h08 on consecutive cycles.
REQ-038 SHALL test PULSE: accept in_sel=3 -> y=8'h08 for exactly 4 cycles with in_ready=0 and busy=1, then y=0 and in_ready=1; in_valid held high during the pulse is not accepted.
REQ-039 SHALL test SCAN: mode=10 for 10 cycles -> y=01,02,04,...,80,01,02; then mode=00 -> y=0 next cycle.
REQ-040 SHALL test out-of-range with NUM_OUT=6: accept in_sel=6 -> y=0 and err high for exactly 1 cycle.
REQ-041 SHALL test reset and enable: rst during the 2nd PULSE cycle -> y=0 and state IDLE on the next edge; en=0 during SCAN -> y=0 next cycle.
